pe_serial_collector: RTL and testbench

Receive end of the bit-serial PE datapath. Collects the LSB-first serial product stream produced by a signed bit-serial multiplier over one 2*BITWIDTH-bit frame, then presents the assembled signed product as a parallel word on a valid/ready interface. Sits between the PE output and the accumulator/writeback logic, in the same fast_clk domain as the PE frame counter.

---
 rtl/pe_pkg.sv | 26 ++
 rtl/pe_result_hold.sv | 60 ++++++
 rtl/pe_serial_collector.sv | 138 +++++++++++++
 tb/tb_pe_serial_collector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg -- shared definitions for the bit-serial PE datapath.
//   pe_clog2   : ceiling log2, usable in constant expressions.
//   pe_pw      : product / frame width derived from the operand width.
//   pe_state_t : frame state encoding (IDLE, SHIFT), also used by the PE
//                frame counter so both ends agree on what "in a frame" means.
package pe_pkg;

    function automatic int pe_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int pe_pw(input int bitwidth);
        return 2 * bitwidth;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pe_state_t;

endpackage

// File: rtl/pe_result_hold.sv
// pe_result_hold -- output register of the serial collector.
// Holds the last assembled product, its valid flag and the sticky overrun
// flag.
//
// Handshake: o_valid high means o_data holds a product that has not been
// consumed; a transfer happens in any cycle with o_valid && i_ready. A new
// word (i_load) is accepted when the register is empty or being drained in
// the same cycle; otherwise it is dropped and o_overrun is set until reset.
//
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : a complete product is presented on i_word this cycle
//   i_word       : the complete product
//   i_ready      : consumer ready
//   o_data       : held product
//   o_valid      : o_data unconsumed
//   o_overrun    : sticky, a completed product was dropped
module pe_result_hold #(
    parameter int PW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [PW-1:0] i_word,
    input  logic          i_ready,
    output logic [PW-1:0] o_data,
    output logic          o_valid,
    output logic          o_overrun
);

    logic [PW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          w_accept;

    // Room for a new word: empty, or the current word leaves this cycle.
    assign w_accept = !r_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            if (w_accept) begin
                r_data  <= i_word;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/pe_serial_collector.sv
// pe_serial_collector -- collects the LSB-first serial product of the
// bit-serial multiplier over one PW = 2*BITWIDTH bit frame and presents the
// assembled signed word on a valid/ready output.
//
// Optional feature macro: PE_COLLECT_FRAME_CHECK_EN
//   defined   : frame_start during a frame pulses frame_err, drops the
//               partial frame and restarts with the current bit as bit 0.
//   undefined : frame_start during a frame is ignored, frame_err is 0.
//
// Ports:
//   fast_clk, rst : clock, synchronous active-high reset
//   bit_in_valid  : bit_in qualifier (gaps allowed)
//   bit_in        : serial product bit, LSB first
//   frame_start   : bit_in is bit 0 of a frame
//   result_data   : assembled product (two's complement, PW bits)
//   result_valid  : result_data unconsumed
//   result_ready  : consumer accepts result_data
//   bit_count     : index of next expected bit in the current frame
//   busy          : frame in progress; this is the FSM state (SHIFT)
//   overrun       : sticky, a completed frame was dropped
//   frame_err     : one-cycle pulse on mid-frame frame_start
module pe_serial_collector
    import pe_pkg::*;
#(
    parameter int  BITWIDTH = 8,
    localparam int PW       = pe_pw(BITWIDTH),
    localparam int CW       = pe_clog2(PW) + 2
) (
    input  logic          fast_clk,
    input  logic          rst,
    input  logic          bit_in_valid,
    input  logic          bit_in,
    input  logic          frame_start,
    output logic [PW-1:0] result_data,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [CW-1:0] bit_count,
    output logic          busy,
    output logic          overrun,
    output logic          frame_err
);

    localparam logic [CW-1:0] LAST_BIT = CW'(PW - 1);

    pe_state_t     r_state, w_state_next;
    logic [PW-1:0] r_shreg, w_shreg_next;
    logic [CW-1:0] r_bit_count, w_bit_count_next;
    logic [PW-1:0] w_word;
    logic          w_done;
    logic          w_frame_err_next;

    // Right shift with the new bit at the MSB: after PW shifts bit 0 sits
    // at position 0, so the shifted value is also the finished word.
    assign w_word = {bit_in, r_shreg[PW-1:1]};

    always_comb begin
        w_state_next     = r_state;
        w_shreg_next     = r_shreg;
        w_bit_count_next = r_bit_count;
        w_done           = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (bit_in_valid && frame_start) begin
                    w_shreg_next     = {bit_in, {(PW-1){1'b0}}};
                    w_bit_count_next = CW'(1);
                    w_state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_in_valid) begin
`ifdef PE_COLLECT_FRAME_CHECK_EN
                    if (frame_start) begin
                        w_shreg_next     = {bit_in, {(PW-1){1'b0}}};
                        w_bit_count_next = CW'(1);
                        w_frame_err_next = 1'b1;
                    end else
`endif
                    if (r_bit_count == LAST_BIT) begin
                        w_shreg_next     = w_word;
                        w_bit_count_next = '0;
                        w_done           = 1'b1;
                        w_state_next     = IDLE;
                    end else begin
                        w_shreg_next     = w_word;
                        w_bit_count_next = r_bit_count + CW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_shreg     <= w_shreg_next;
            r_bit_count <= w_bit_count_next;
        end
    end

`ifdef PE_COLLECT_FRAME_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_next;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    pe_result_hold #(
        .PW(PW)
    ) u_result_hold (
        .i_clk     (fast_clk),
        .i_rst     (rst),
        .i_load    (w_done),
        .i_word    (w_word),
        .i_ready   (result_ready),
        .o_data    (result_data),
        .o_valid   (result_valid),
        .o_overrun (overrun)
    );

    assign bit_count = r_bit_count;
    assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_pe_serial_collector.sv
module tb_pe_serial_collector;

    localparam int PW = 16;
    localparam int CW = 6;
`ifdef PE_COLLECT_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          fast_clk = 1'b0;
    logic          rst;
    logic          bit_in_valid;
    logic          bit_in;
    logic          frame_start;
    logic [PW-1:0] result_data;
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] bit_count;
    logic          busy;
    logic          overrun;
    logic          frame_err;

    always #5 fast_clk = ~fast_clk;

    pe_serial_collector #(.BITWIDTH(8)) dut (
        .fast_clk     (fast_clk),
        .rst          (rst),
        .bit_in_valid (bit_in_valid),
        .bit_in       (bit_in),
        .frame_start  (frame_start),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .bit_count    (bit_count),
        .busy         (busy),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a list of received bits; when it holds PW bits the product
    // is the weighted sum of those bits.
    bit            m_bits[$];
    bit            m_in_frame = 1'b0;
    logic [PW-1:0] m_data     = '0;
    bit            m_valid    = 1'b0;
    bit            m_overrun  = 1'b0;
    bit            m_ferr     = 1'b0;

    always @(posedge fast_clk) begin
        logic [PW-1:0] word;
        bit            done;
        bit            hs;
        hs     = m_valid && (result_ready === 1'b1);
        done   = 1'b0;
        word   = '0;
        m_ferr = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_in_frame = 1'b0;
            m_valid    = 1'b0;
            m_data     = '0;
            m_overrun  = 1'b0;
        end else begin
            if (bit_in_valid) begin
                if (!m_in_frame) begin
                    if (frame_start) begin
                        m_bits.delete();
                        m_bits.push_back(bit_in);
                        m_in_frame = 1'b1;
                    end
                end else if (CHECK_EN && frame_start) begin
                    m_bits.delete();
                    m_bits.push_back(bit_in);
                    m_ferr = 1'b1;
                end else begin
                    m_bits.push_back(bit_in);
                    if (m_bits.size() == PW) begin
                        foreach (m_bits[i]) word = word | (PW'(m_bits[i]) << i);
                        done = 1'b1;
                        m_bits.delete();
                        m_in_frame = 1'b0;
                    end
                end
            end
            if (done) begin
                if (!m_valid || result_ready) begin
                    m_data  = word;
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge fast_clk) begin
        if (cmp_en) begin
            check("cyc_result_valid", 32'(result_valid), 32'(m_valid));
            check("cyc_result_data",  32'(result_data),  32'(m_data));
            check("cyc_overrun",      32'(overrun),      32'(m_overrun));
            check("cyc_busy",         32'(busy),         32'(m_in_frame));
            check("cyc_bit_count",    32'(bit_count),    32'(m_bits.size()));
            check("cyc_frame_err",    32'(frame_err),    32'(m_ferr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input logic s);
        bit_in_valid = 1'b1;
        bit_in       = b;
        frame_start  = s;
        @(posedge fast_clk);
        #1;
        bit_in_valid = 1'b0;
        bit_in       = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic send_frame(input logic [PW-1:0] w);
        for (int i = 0; i < PW; i++) send_bit(w[i], i == 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [PW-1:0] w;
        rst          = 1'b1;
        bit_in_valid = 1'b0;
        bit_in       = 1'b0;
        frame_start  = 1'b0;
        result_ready = 1'b1;
        repeat (2) @(posedge fast_clk);
        #1;
        check("rst_result_valid", 32'(result_valid), 32'h0);
        check("rst_result_data",  32'(result_data),  32'h0);
        check("rst_busy",         32'(busy),         32'h0);
        check("rst_bit_count",    32'(bit_count),    32'h0);
        check("rst_overrun",      32'(overrun),      32'h0);
        check("rst_frame_err",    32'(frame_err),    32'h0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // -3, continuous bits
        w = 16'hFFFD;
        for (int i = 0; i < PW; i++) begin
            send_bit(w[i], i == 0);
            if (i == 0)  check("t1_busy_after_bit0", 32'(busy), 32'h1);
            if (i == 14) check("t1_valid_before_last", 32'(result_valid), 32'h0);
        end
        check("t1_valid",     32'(result_valid), 32'h1);
        check("t1_data",      32'(result_data),  32'hFFFD);
        check("t1_model",     32'(m_data),       32'hFFFD);
        check("t1_overrun",   32'(overrun),      32'h0);
        check("t1_busy_done", 32'(busy),         32'h0);
        idle_cycle();
        check("t1_valid_drop", 32'(result_valid), 32'h0);
        check("t1_data_hold",  32'(result_data),  32'hFFFD);

        // same frame, valid every other cycle
        for (int i = 0; i < PW; i++) begin
            send_bit(w[i], i == 0);
            if (i < PW - 1) check("t2_count_valid", 32'(bit_count), 32'(i + 1));
            else            check("t2_valid", 32'(result_valid), 32'h1);
            idle_cycle();
            if (i < PW - 1) check("t2_count_gap", 32'(bit_count), 32'(i + 1));
        end
        check("t2_data", 32'(result_data), 32'hFFFD);

        // back-to-back frames, ready held high
        send_frame(16'h0024);
        check("t3_data0",  32'(result_data),  32'h0024);
        check("t3_valid0", 32'(result_valid), 32'h1);
        w = 16'h8000;
        for (int i = 0; i < PW; i++) begin
            send_bit(w[i], i == 0);
            if (i == 0) begin
                check("t3_valid_gap", 32'(result_valid), 32'h0);
                check("t3_busy2",     32'(busy),         32'h1);
            end
        end
        check("t3_data1",  32'(result_data),  32'h8000);
        check("t3_model1", 32'(m_data),       32'h8000);
        check("t3_valid1", 32'(result_valid), 32'h1);
        idle_cycle();

        // consumer stalled: second frame dropped
        result_ready = 1'b0;
        send_frame(16'h0001);
        check("t4_data0",    32'(result_data),  32'h0001);
        check("t4_overrun0", 32'(overrun),      32'h0);
        send_frame(16'h0002);
        check("t4_data_kept", 32'(result_data), 32'h0001);
        check("t4_overrun1",  32'(overrun),     32'h1);
        check("t4_valid",     32'(result_valid), 32'h1);
        result_ready = 1'b1;
        idle_cycle();
        check("t4_valid_drop", 32'(result_valid), 32'h0);
        check("t4_data_hold",  32'(result_data),  32'h0001);

        // frame_start reasserted at bit 5
        w = 16'hAAAA;
        for (int i = 0; i < 5; i++) send_bit(w[i], i == 0);
        w = 16'h1234;
        for (int i = 0; i < PW; i++) begin
            send_bit(w[i], i == 0);
            if (i == 0) begin
                check("t5_frame_err", 32'(frame_err), 32'(CHECK_EN));
                check("t5_count",     32'(bit_count), CHECK_EN ? 32'd1 : 32'd6);
            end
            if (i == 1) check("t5_frame_err_pulse", 32'(frame_err), 32'h0);
            if (!CHECK_EN && i == 10) begin
                check("t5_nochk_valid", 32'(result_valid), 32'h1);
                check("t5_nochk_data",  32'(result_data),  32'h468A);
                check("t5_nochk_model", 32'(m_data),       32'h468A);
            end
        end
        if (CHECK_EN) begin
            check("t5_chk_valid", 32'(result_valid), 32'h1);
            check("t5_chk_data",  32'(result_data),  32'h1234);
        end else begin
            check("t5_nochk_idle", 32'(busy), 32'h0);
        end
        idle_cycle();

        // reset in the middle of a frame
        w = 16'h5A5A;
        for (int i = 0; i < 9; i++) send_bit(w[i], i == 0);
        rst = 1'b1;
        send_bit(w[9], 1'b0);
        rst = 1'b0;
        check("t6_valid",     32'(result_valid), 32'h0);
        check("t6_data",      32'(result_data),  32'h0);
        check("t6_overrun",   32'(overrun),      32'h0);
        check("t6_busy",      32'(busy),         32'h0);
        check("t6_bit_count", 32'(bit_count),    32'h0);
        check("t6_frame_err", 32'(frame_err),    32'h0);
        send_frame(16'h00FF);
        check("t6_new_data",    32'(result_data),  32'h00FF);
        check("t6_new_valid",   32'(result_valid), 32'h1);
        check("t6_new_overrun", 32'(overrun),      32'h0);
        idle_cycle();
        idle_cycle();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
